// File: rtl/alu_sched_if.sv
// Requester-side bundle of the ALU scheduler: per-requester request fields
// plus the shared response bus returned to the granted requester.
interface alu_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic [11*NREQ-1:0]   req_op;
  logic [NREQ-1:0]      rsp_valid;
  logic [15:0]          rsp_data;
  logic                 rsp_z;
  logic                 rsp_err;

  // Requesters (issue logic) drive requests and consume responses.
  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, rsp_valid, rsp_data, rsp_z, rsp_err
  );

  // The scheduler accepts requests and produces responses.
  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, rsp_valid, rsp_data, rsp_z, rsp_err
  );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered 16-bit ALU among NREQ
// requesters; one operation in flight, response returned as a 1-cycle pulse.
module alu_sched #(
  parameter int NREQ = 4
) (
  input  logic        clk_n,
  input  logic        rst_n,
  alu_sched_if.slave  bus,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [10:0] alu_opcode,
  input  logic [15:0] alu_out,
  input  logic        alu_z
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [10:0] OP_NOOP = 11'h001;
  localparam logic [10:0] OP_CPY  = 11'h002;
  localparam logic [10:0] OP_ADD  = 11'h004;
  localparam logic [10:0] OP_SUB  = 11'h008;
  localparam logic [10:0] OP_MUL  = 11'h010;
  localparam logic [10:0] OP_AND  = 11'h020;
  localparam logic [10:0] OP_OR   = 11'h040;
  localparam logic [10:0] OP_NOT  = 11'h080;
  localparam logic [10:0] OP_XOR  = 11'h100;
  localparam logic [10:0] OP_LS   = 11'h200;
  localparam logic [10:0] OP_RS   = 11'h400;
  localparam logic [10:0] OP_ZERO = 11'h7F8;
  localparam logic [10:0] OP_NOR  = 11'h7FE;
  localparam logic [10:0] OP_XNOR = 11'h7FD;
  localparam logic [10:0] OP_NAND = 11'h7FB;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  // NOOP is deliberately absent: issuing it would be a silent no-op on the ALU.
  function automatic logic op_legal(input logic [10:0] op);
    case (op)
      OP_CPY, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_NOT, OP_XOR,
      OP_LS, OP_RS, OP_ZERO, OP_NOR, OP_XNOR, OP_NAND: op_legal = 1'b1;
      default:                                         op_legal = 1'b0;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [IW-1:0]   last_grant_q;
  logic [IW-1:0]   grant_q;
  logic [15:0]     a_q, b_q;
  logic [10:0]     op_q;
  logic [15:0]     rsp_data_q;
  logic            rsp_z_q;
  logic            err_q;

  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand;
  logic [15:0]     sel_a, sel_b;
  logic [10:0]     sel_op;
  logic            sel_legal;
  logic            accept;

  // Scan upward starting one past the last grant so every waiter is reached.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_grant_q) + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_a     = bus.req_a[16*gnt_idx +: 16];
    sel_b     = bus.req_b[16*gnt_idx +: 16];
    sel_op    = bus.req_op[11*gnt_idx +: 11];
    sel_legal = op_legal(sel_op);
    accept    = (state_q == S_IDLE) && gnt_found;
  end

  // NOTE: sequential state uses non-blocking (<=) so all registers update
  // from pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_found) state_d = sel_legal ? S_ISSUE : S_RESP;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    alu_opcode    = OP_NOOP;
    if (accept)                bus.req_ready[gnt_idx] = 1'b1;
    if (state_q == S_RESP)     bus.rsp_valid[grant_q] = 1'b1;
    if (state_q == S_ISSUE)    alu_opcode = op_q;
    bus.rsp_err = (state_q == S_RESP) && err_q;
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_z    = rsp_z_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;

  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IW'(NREQ - 1);
      grant_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_NOOP;
      rsp_data_q   <= '0;
      rsp_z_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        a_q          <= sel_a;
        b_q          <= sel_b;
        op_q         <= sel_op;
        grant_q      <= gnt_idx;
        last_grant_q <= gnt_idx;
        err_q        <= !sel_legal;
        // Rejected requests report a clean zero result rather than stale data.
        if (!sel_legal) begin
          rsp_data_q <= '0;
          rsp_z_q    <= 1'b0;
        end
      end
      if (state_q == S_WAIT) begin
        rsp_data_q <= alu_out;
        rsp_z_q    <= alu_z;
      end
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: a behavioural registered ALU sits on the ALU
// side, expected results are hand-computed constants.
module tb_alu_sched;

  localparam int NREQ = 4;

  localparam logic [10:0] OP_NOOP = 11'h001;
  localparam logic [10:0] OP_ADD  = 11'h004;
  localparam logic [10:0] OP_SUB  = 11'h008;
  localparam logic [10:0] OP_MUL  = 11'h010;
  localparam logic [10:0] OP_AND  = 11'h020;
  localparam logic [10:0] OP_XOR  = 11'h100;
  localparam logic [10:0] OP_LS   = 11'h200;
  localparam logic [10:0] OP_NAND = 11'h7FB;

  logic        clk_n = 1'b0;
  logic        rst_n;
  logic [15:0] alu_a, alu_b;
  logic [10:0] alu_opcode;
  logic [15:0] alu_out = 16'h0000;
  logic        alu_z   = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  alu_sched_if #(.NREQ(NREQ)) bus ();

  alu_sched #(.NREQ(NREQ)) dut (
    .clk_n      (clk_n),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_z      (alu_z)
  );

  always #5 clk_n = ~clk_n;

  function automatic logic [15:0] alu_fn(input logic [10:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      11'h002: alu_fn = a;
      11'h004: alu_fn = a + b;
      11'h008: alu_fn = a - b;
      11'h010: alu_fn = a * b;
      11'h020: alu_fn = a & b;
      11'h040: alu_fn = a | b;
      11'h080: alu_fn = ~a;
      11'h100: alu_fn = a ^ b;
      11'h200: alu_fn = a << b;
      11'h400: alu_fn = a >> b;
      11'h7F8: alu_fn = 16'h0000;
      11'h7FE: alu_fn = ~(a | b);
      11'h7FD: alu_fn = ~(a ^ b);
      11'h7FB: alu_fn = ~(a & b);
      default: alu_fn = 16'h0000;
    endcase
  endfunction

  // Registered ALU: holds its output while the opcode is NOOP.
  always @(posedge clk_n) begin
    if (alu_opcode != OP_NOOP) begin
      alu_out <= alu_fn(alu_opcode, alu_a, alu_b);
      alu_z   <= (alu_fn(alu_opcode, alu_a, alu_b) == 16'h0000);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int r, input logic [15:0] a, input logic [15:0] b, input logic [10:0] op);
    bus.req_valid[r]         = 1'b1;
    bus.req_a[16*r +: 16]    = a;
    bus.req_b[16*r +: 16]    = b;
    bus.req_op[11*r +: 11]   = op;
  endtask

  // Called just after a posedge with the DUT idle; returns just after the
  // posedge at which the DUT is idle again.
  task automatic run_op(input string tag, input int r, input logic [15:0] a, input logic [15:0] b,
                        input logic [10:0] op, input logic [15:0] exp_d, input logic exp_z,
                        input logic exp_err);
    drive(r, a, b, op);
    @(negedge clk_n);
    check({tag, ".ready"}, 32'(bus.req_ready), 32'(1) << r);
    check({tag, ".op_idle"}, 32'(alu_opcode), 32'(OP_NOOP));
    @(posedge clk_n); #1;
    bus.req_valid[r] = 1'b0;
    if (!exp_err) begin
      @(negedge clk_n);
      check({tag, ".issue_op"}, 32'(alu_opcode), 32'(op));
      check({tag, ".issue_a"}, 32'(alu_a), 32'(a));
      check({tag, ".issue_b"}, 32'(alu_b), 32'(b));
      check({tag, ".issue_rsp"}, 32'(bus.rsp_valid), 32'h0);
      @(negedge clk_n);
      check({tag, ".wait_op"}, 32'(alu_opcode), 32'(OP_NOOP));
      check({tag, ".wait_rsp"}, 32'(bus.rsp_valid), 32'h0);
    end
    @(negedge clk_n);
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(1) << r);
    check({tag, ".rsp_data"}, 32'(bus.rsp_data), 32'(exp_d));
    check({tag, ".rsp_z"}, 32'(bus.rsp_z), 32'(exp_z));
    check({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    check({tag, ".rsp_op"}, 32'(alu_opcode), 32'(OP_NOOP));
    @(posedge clk_n); #1;
    check({tag, ".rsp_end"}, 32'(bus.rsp_valid), 32'h0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".ready"}, 32'(bus.req_ready), 32'h0);
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, ".rsp_data"}, 32'(bus.rsp_data), 32'h0);
    check({tag, ".rsp_z"}, 32'(bus.rsp_z), 32'h0);
    check({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'h0);
    check({tag, ".alu_a"}, 32'(alu_a), 32'h0);
    check({tag, ".alu_b"}, 32'(alu_b), 32'h0);
    check({tag, ".alu_op"}, 32'(alu_opcode), 32'(OP_NOOP));
  endtask

  task automatic do_reset();
    @(negedge clk_n);
    rst_n = 1'b0;
    #2;
    check_reset_values("rst");
    @(negedge clk_n);
    rst_n = 1'b1;
    @(posedge clk_n); #1;
  endtask

  logic [15:0] rr_exp [NREQ];

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = {NREQ{OP_NOOP}};
    #2;
    check_reset_values("por");
    #20;
    rst_n = 1'b1;
    @(posedge clk_n); #1;

    run_op("add",  1, 16'h0003, 16'h0004, OP_ADD,  16'h0007, 1'b0, 1'b0);
    run_op("sub",  0, 16'h1234, 16'h1234, OP_SUB,  16'h0000, 1'b1, 1'b0);
    run_op("ill",  2, 16'h5555, 16'h00AA, 11'h003, 16'h0000, 1'b0, 1'b1);
    run_op("noop", 3, 16'h0001, 16'h0001, OP_NOOP, 16'h0000, 1'b0, 1'b1);
    run_op("mul",  3, 16'h0100, 16'h0100, OP_MUL,  16'h0000, 1'b1, 1'b0);
    run_op("ls",   0, 16'h0001, 16'h0004, OP_LS,   16'h0010, 1'b0, 1'b0);
    run_op("nand", 1, 16'hFFFF, 16'h00FF, OP_NAND, 16'hFF00, 1'b0, 1'b0);

    // All requesters held valid from reset: grants 0,1,2,3,0 four cycles apart.
    do_reset();
    rr_exp[0] = 16'h0003;
    rr_exp[1] = 16'h0007;
    rr_exp[2] = 16'h0FF0;
    rr_exp[3] = 16'hF000;
    drive(0, 16'h0001, 16'h0002, OP_ADD);
    drive(1, 16'h000A, 16'h0003, OP_SUB);
    drive(2, 16'h00FF, 16'h0F0F, OP_XOR);
    drive(3, 16'hF0F0, 16'hFF00, OP_AND);
    for (int g = 0; g < 5; g++) begin
      @(negedge clk_n);
      check($sformatf("rr%0d.ready", g), 32'(bus.req_ready), 32'(1) << (g % NREQ));
      @(negedge clk_n);
      check($sformatf("rr%0d.busy_ready", g), 32'(bus.req_ready), 32'h0);
      @(negedge clk_n);
      check($sformatf("rr%0d.wait_ready", g), 32'(bus.req_ready), 32'h0);
      @(negedge clk_n);
      check($sformatf("rr%0d.rsp_valid", g), 32'(bus.rsp_valid), 32'(1) << (g % NREQ));
      check($sformatf("rr%0d.rsp_data", g), 32'(bus.rsp_data), 32'(rr_exp[g % NREQ]));
      check($sformatf("rr%0d.resp_ready", g), 32'(bus.req_ready), 32'h0);
    end
    bus.req_valid = '0;

    // Reset during WAIT of a MUL drops the request with no response.
    do_reset();
    drive(2, 16'h0003, 16'h0005, OP_MUL);
    @(negedge clk_n);
    check("mrst.ready", 32'(bus.req_ready), 32'h4);
    @(posedge clk_n); #1;
    bus.req_valid[2] = 1'b0;
    @(posedge clk_n); #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mrst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_n);
      check($sformatf("mrst.norsp%0d", c), 32'(bus.rsp_valid), 32'h0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_n);
      check($sformatf("mrst.idle%0d", c), 32'(bus.rsp_valid), 32'h0);
    end
    @(posedge clk_n); #1;
    run_op("post", 2, 16'h0003, 16'h0005, OP_MUL, 16'h000F, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one registered 16-bit ALU between `NREQ` requesters. Each requester presents operands and an 11-bit one-hot opcode with a valid/ready handshake. The block issues one operation at a time to the ALU and captures the result and zero flag. It then returns them to the originating requester as a one-cycle response pulse. It sits between the instruction-issue logic and the ALU, and is the only driver of the ALU's `a`, `b` and `opcode` inputs.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `clk_n`  in  1: clock; all state updates on posedge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  NREQ: request present, one bit per requester.
- `req_ready`  out  NREQ: request accepted this cycle; at most one bit high.
- `req_a`  in  16*NREQ: operand A; requester i uses bits [16i+15:16i].
- `req_b`  in  16*NREQ: operand B; same packing as `req_a`.
- `req_op`  in  11*NREQ: opcode; requester i uses bits [11i+10:11i].
- `rsp_valid`  out  NREQ: one-cycle result pulse to the granted requester.
- `rsp_data`  out  16: result; valid only while a `rsp_valid` bit is high.
- `rsp_z`  out  1: ALU zero flag for the result.
- `rsp_err`  out  1: the request carried an illegal opcode and was not issued.
- `alu_a`, `alu_b`  out  16: ALU operands.
- `alu_opcode`  out  11: ALU opcode.
- `alu_out`  in  16: ALU registered result.
- `alu_z`  in  1: ALU zero flag.

## Operation
- Opcode encoding:
  - NOOP 11'h001
  - CPY 11'h002
  - ADD 11'h004
  - SUB 11'h008
  - MUL 11'h010
  - AND 11'h020
  - OR 11'h040
  - NOT 11'h080
  - XOR 11'h100
  - LS 11'h200
  - RS 11'h400
  - ZERO 11'h7F8
  - NOR 11'h7FE
  - XNOR 11'h7FD
  - NAND 11'h7FB
- Legal request opcodes are the 14 listed above, excluding NOOP. Any other value, NOOP included, is illegal.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is high, grant the first valid requester scanning upward from `(last_grant+1) mod NREQ`.
  - `req_ready[g]` is combinational and high this cycle.
  - On the posedge, latch a, b, op and g, and set `last_grant` = g.
  - Legal op: go to ISSUE. Illegal op: go to RESP with the error flag set.
- ISSUE: drive `alu_opcode` = latched op for this cycle only; go to WAIT.
- WAIT: `alu_opcode` = NOOP. On the posedge, latch `alu_out` into `rsp_data` and `alu_z` into `rsp_z`, then go to RESP.
- RESP:
  - Set `rsp_valid[g]` = 1 for one cycle. There is no response backpressure.
  - Error case: `rsp_data` = 16'h0000, `rsp_z` = 0, `rsp_err` = 1.
  - Go to IDLE.
- `alu_opcode` is NOOP in every state except ISSUE, so the ALU holds its output.
- `alu_a` and `alu_b` always drive the latched operands.
- Results are 16-bit exactly as produced by the ALU (for example, MUL is truncated). The scheduler does no arithmetic.
- Requesters must hold `req_valid` and their fields stable until `req_ready`. Deasserting `req_valid` before grant withdraws the request.

## Timing
- Reset values:
  - state IDLE
  - `last_grant` = NREQ-1, so requester 0 has first priority
  - `req_ready` = 0, `rsp_valid` = 0
  - `rsp_data` = 0, `rsp_z` = 0, `rsp_err` = 0
  - `alu_a` = 0, `alu_b` = 0, `alu_opcode` = NOOP
- Latency, legal op: accepted at edge E, ALU captures at E+1, result latched at E+2, `rsp_valid` high during cycle E+2..E+3. The next accept is possible at edge E+4.
- Latency, illegal op: `rsp_valid` high in the cycle right after accept. The next accept is possible 2 edges after accept.
- Throughput: one operation per 4 cycles.
- `req_ready` is 0 in ISSUE, WAIT and RESP, even when requests are valid.
- Simultaneous requests: only one grant per IDLE cycle. A requester that keeps `req_valid` high waits at most NREQ-1 grants to others.
- Reset mid-operation returns to IDLE immediately. The in-flight request is dropped with no response, and `alu_opcode` goes to NOOP.

## Test plan
- Single ADD: requester 1, a=16'h0003, b=16'h0004. Expect `req_ready[1]` for 1 cycle, then `rsp_valid[1]` 3 cycles later with data 16'h0007, z=0, err=0.
- SUB equal operands: a=b=16'h1234 gives data 16'h0000, z=1.
- All 4 requesters valid and held after reset: grants in order 0,1,2,3,0, with each response on the matching `rsp_valid` bit, 4 cycles apart.
- Illegal opcode 11'h003 from requester 2: `alu_opcode` never leaves NOOP; `rsp_valid[2]` with data 0, z=0, err=1 one cycle after accept.
- MUL a=16'h0100, b=16'h0100: data 16'h0000, z=1 (truncation). LS a=16'h0001, b=16'h0004: data 16'h0010.
- `rst_n` low during WAIT of a MUL: no `rsp_valid`; all outputs return to reset values asynchronously; the next request after release is granted normally.
